jpeg_bitstream_buffer: RTL and testbench
========================================

# jpeg_bitstream_buffer

Parametrised successor bit buffer for the JPEG decoder front end. It accepts the entropy-coded byte stream, stores it in a circular byte RAM, and presents an MSB-first window of OUT_W bits that the Huffman decoder consumes by popping 0..OUT_W bits per cycle. Compared with the fixed 8-byte/32-bit buffer, it adds configurable depth and window width, a drain-end `outport_last_o` with masked tail bits, pop clamping, a fill-level output, and optional JPEG byte unstuffing with marker detection.

## Interface
- DEPTH_BYTES, 16, RAM depth in bytes; power of two, >= OUT_W/8 + 2
- OUT_W, 32, output window width in bits; multiple of 8, 8..56
- PW (localparam), $clog2(OUT_W)+1, pop field width
- CW (localparam), $clog2(DEPTH_BYTES*8)+1, bit-count width
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  reset; synchronous and active-high
- img_start_i  in  1  flush all state at start of image
- img_end_i  in  1  force drain mode
- inport_valid_i  in  1  byte valid
- inport_data_i  in  8  byte
- inport_last_i  in  1  final byte of image, qualified by valid and accept
- inport_accept_o  out  1  byte taken when valid and accept are both high
- outport_pop_i  in  PW  bits consumed this cycle; effective only while valid is high
- outport_valid_o  out  1  window holds usable data
- outport_data_o  out  OUT_W  window, MSB = next bit
- outport_last_o  out  1  window contains the final bits of the image
- level_o  out  CW  stored bit count
- marker_o  out  1  one-cycle pulse when a marker is found (UNSTUFF build only)
- marker_code_o  out  8  code byte of the last marker, held

## Operation
- State: ram_q[DEPTH_BYTES], rd_ptr_q (bit pointer, log2(DEPTH_BYTES*8) bits, wraps naturally), wr_ptr_q (byte pointer), count_q (CW bits), drain_q.
- Priority: rst_i, then img_start_i, then normal operation. rst_i and img_start_i clear pointers, count, drain_q, the pending-FF flag and marker_code_o. rst_i also zeroes the RAM.
- Accept: `inport_accept_o = count_q <= DEPTH_BYTES*8 - 8`. This is combinational from registered state only.
- Push: the byte is written at wr_ptr_q, wr_ptr_q increments by 1, and count increases by 8.
- Pop: pop_eff = min(outport_pop_i, OUT_W, count_q). rd_ptr_q advances by pop_eff; count decreases by pop_eff. count_q never underflows.
- Simultaneous push and pop: count_q_next = count_q + 8 - pop_eff.
- Window: take bytes rd_ptr_q[top:3] .. +OUT_W/8 (modulo DEPTH_BYTES), shift left by rd_ptr_q[2:0], and output the top OUT_W bits.
- Valid: `outport_valid_o = count_q >= OUT_W || (drain_q && count_q != 0)`.
- Last: `outport_last_o = drain_q && count_q != 0 && count_q <= OUT_W`. While last is high, window bits below count_q are forced to zero.
- drain_q is set by an accepted byte carrying inport_last_i, or by img_end_i. It stays set until img_start_i or rst_i.
- `level_o = count_q`.

## Timing
- Reset values: inport_accept_o=1, outport_valid_o=0, outport_data_o=0, outport_last_o=0, level_o=0, marker_o=0, marker_code_o=0.
- Push-to-visible latency: 1 cycle. The byte appears in count_q and the window the cycle after acceptance.
- Pop takes effect on the next edge. The window is combinational from registered state, so there is no input-to-output combinational path except pop to nothing.
- Full: with count_q > DEPTH*8-8, accept stays low until a pop frees 8 bits; accept recovers on the cycle after that pop.
- Empty while not draining: valid stays low even with 1..OUT_W-1 bits stored.
- Wrap: the window read wraps modulo DEPTH_BYTES, and rd_ptr_q wraps modulo DEPTH_BYTES*8 with no gap.
- img_start_i during an active transfer: a byte presented in that cycle is dropped, and the buffer reads empty on the next cycle.

## Configuration
- JPEG_BITBUF_UNSTUFF_EN defined:
  - An input 0xFF is held in a pending register and not yet pushed.
  - Next byte 0x00: push 0xFF and discard the 0x00.
  - Next byte 0xFF: keep one pending FF and discard the other (fill byte).
  - Any other next byte: push nothing, pulse marker_o, latch marker_code_o, and set drain_q.
  - If a pending FF meets inport_last_i, or img_end_i fires while FF is pending, push 0xFF.
  - Accept is additionally gated while a pending FF flushes on a full buffer.
- Macro undefined: bytes pass through unmodified, marker_o is tied to 0, and marker_code_o is tied to 0.

## Structure
- Package jpeg_bitbuffer_pkg holds the marker code constants (SOI, EOI, RSTn range) and a clog2 helper function.
- Sub-module jpeg_unstuff contains the pending-FF stage and marker detect. It sits between the input port and the RAM write, and is instantiated only under the macro.

## Test plan
- Default params: push 0x12,0x34,0x56,0x78 then pop 0 -> valid=1, data=0x12345678. Then pop 4 -> next-cycle data=0x2345678x with the top nibble 0x2, and level=28.
- Fill 16 bytes with no pops -> accept drops when count=128 (the 16th byte was accepted at count 120). Pop 8 -> accept=1 on the following cycle.
- Stream 40 bytes with pops of 5,3,17 repeating -> all bits out match the reference bitstream across pointer wrap.
- Push 0xAB with last, then pop 0 -> valid=1, last=1, data=0xAB000000. Then pop 32 -> clamped to 8, so count=0 and valid=0.
- UNSTUFF build: bytes 0xFF,0x00,0xFF,0xFF,0xD9 -> one 0xFF stored, marker_o pulses, marker_code_o=0xD9, drain_q=1.
- img_start_i mid-stream with count=72 -> next cycle level=0, valid=0, accept=1.

Source files
------------

// File: rtl/jpeg_bitbuffer_pkg.sv
// Shared constants and helpers for the JPEG bit buffer.
package jpeg_bitbuffer_pkg;
  localparam logic [7:0] BYTE_FF  = 8'hFF;
  localparam logic [7:0] MRK_SOI  = 8'hD8;
  localparam logic [7:0] MRK_EOI  = 8'hD9;
  localparam logic [7:0] MRK_RST0 = 8'hD0;
  localparam logic [7:0] MRK_RST7 = 8'hD7;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/jpeg_unstuff.sv
// Pending-FF unstuffing stage and marker detect between input port and RAM write.
module jpeg_unstuff
  import jpeg_bitbuffer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       fire_i,
  input  logic [7:0] data_i,
  input  logic       last_i,
  input  logic       end_i,
  input  logic       space_i,
  output logic       push_o,
  output logic [7:0] push_data_o,
  output logic       drain_o,
  output logic       hold_o,
  output logic       marker_o,
  output logic [7:0] marker_code_o
);
  logic       pend_q, pend_d, flush_q, flush_d, marker_q, marker_d;
  logic [7:0] code_q, code_d;

  always_comb begin
    pend_d      = pend_q;
    flush_d     = flush_q;
    marker_d    = 1'b0;
    code_d      = code_q;
    push_o      = 1'b0;
    push_data_o = BYTE_FF;
    drain_o     = end_i;
    if (fire_i) begin
      if (last_i) drain_o = 1'b1;
      if (!pend_q) begin
        // A trailing FF carrying last has no successor, so it goes straight in.
        if (data_i == BYTE_FF && !last_i) pend_d = 1'b1;
        else begin
          push_o      = 1'b1;
          push_data_o = data_i;
        end
      end else if (data_i == 8'h00) begin
        push_o = 1'b1;
        pend_d = 1'b0;
      end else if (data_i == BYTE_FF) begin
        if (last_i) begin
          push_o = 1'b1;
          pend_d = 1'b0;
        end
      end else begin
        pend_d   = 1'b0;
        marker_d = 1'b1;
        code_d   = data_i;
        drain_o  = 1'b1;
      end
    end else if (pend_q && (end_i || flush_q)) begin
      // Flush waits for room; the input port stays closed meanwhile.
      if (space_i) begin
        push_o  = 1'b1;
        pend_d  = 1'b0;
        flush_d = 1'b0;
      end else flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      pend_q   <= 1'b0;
      flush_q  <= 1'b0;
      marker_q <= 1'b0;
      code_q   <= '0;
    end else begin
      pend_q   <= pend_d;
      flush_q  <= flush_d;
      marker_q <= marker_d;
      code_q   <= code_d;
    end
  end

  assign hold_o        = flush_q;
  assign marker_o      = marker_q;
  assign marker_code_o = code_q;
endmodule

// File: rtl/jpeg_bitstream_buffer.sv
// Circular byte RAM presenting an MSB-first OUT_W-bit window with variable pops.
// Optional FF-unstuffing / marker detect when JPEG_BITBUF_UNSTUFF_EN is defined.
module jpeg_bitstream_buffer
  import jpeg_bitbuffer_pkg::*;
#(
  parameter int DEPTH_BYTES = 16,
  parameter int OUT_W       = 32,
  localparam int PW         = clog2(OUT_W) + 1,
  localparam int CW         = clog2(DEPTH_BYTES*8) + 1
)(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             img_start_i,
  input  logic             img_end_i,
  input  logic             inport_valid_i,
  input  logic [7:0]       inport_data_i,
  input  logic             inport_last_i,
  output logic             inport_accept_o,
  input  logic [PW-1:0]    outport_pop_i,
  output logic             outport_valid_o,
  output logic [OUT_W-1:0] outport_data_o,
  output logic             outport_last_o,
  output logic [CW-1:0]    level_o,
  output logic             marker_o,
  output logic [7:0]       marker_code_o
);
  localparam int AW  = clog2(DEPTH_BYTES);
  localparam int RPW = AW + 3;
  localparam int NB  = OUT_W/8 + 1;

  logic [7:0]       ram_q [DEPTH_BYTES];
  logic [RPW-1:0]   rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q, count_d, pop_req, pop_eff;
  logic             drain_q, space, fire, push, set_drain;
  logic [7:0]       push_data;
  logic [NB*8-1:0]  win_raw;
  logic [OUT_W-1:0] win_top, win_mask;

  assign space = count_q <= CW'(DEPTH_BYTES*8 - 8);
  assign fire  = inport_valid_i && inport_accept_o && !img_start_i;

`ifdef JPEG_BITBUF_UNSTUFF_EN
  logic hold;
  jpeg_unstuff u_unstuff (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (img_start_i),
    .fire_i       (fire),
    .data_i       (inport_data_i),
    .last_i       (inport_last_i),
    .end_i        (img_end_i),
    .space_i      (space),
    .push_o       (push),
    .push_data_o  (push_data),
    .drain_o      (set_drain),
    .hold_o       (hold),
    .marker_o     (marker_o),
    .marker_code_o(marker_code_o)
  );
  assign inport_accept_o = space && !hold;
`else
  assign inport_accept_o = space;
  assign push            = fire;
  assign push_data       = inport_data_i;
  assign set_drain       = (fire && inport_last_i) || img_end_i;
  assign marker_o        = 1'b0;
  assign marker_code_o   = '0;
`endif

  assign outport_valid_o = count_q >= CW'(OUT_W) || (drain_q && count_q != '0);
  assign outport_last_o  = drain_q && count_q != '0 && count_q <= CW'(OUT_W);
  assign level_o         = count_q;

  always_comb begin
    pop_req = CW'(outport_pop_i);
    if (pop_req > CW'(OUT_W)) pop_req = CW'(OUT_W);
    if (pop_req > count_q)    pop_req = count_q;
    pop_eff = outport_valid_o ? pop_req : '0;
    count_d = count_q + (push ? CW'(8) : CW'(0)) - pop_eff;
  end

  // One spare byte beyond the window covers any sub-byte bit offset.
  always_comb begin
    win_raw = '0;
    for (int k = 0; k < NB; k++)
      win_raw[(NB-1-k)*8 +: 8] = ram_q[rd_ptr_q[RPW-1:3] + AW'(k)];
    win_top = OUT_W'((win_raw << rd_ptr_q[2:0]) >> 8);
    for (int i = 0; i < OUT_W; i++)
      win_mask[i] = CW'(OUT_W - 1 - i) < count_q;
    outport_data_o = outport_last_o ? (win_top & win_mask) : win_top;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drain_q  <= 1'b0;
      for (int k = 0; k < DEPTH_BYTES; k++) ram_q[k] <= '0;
    end else if (img_start_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drain_q  <= 1'b0;
    end else begin
      if (push) begin
        ram_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      rd_ptr_q <= rd_ptr_q + RPW'(pop_eff);
      count_q  <= count_d;
      if (set_drain) drain_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_jpeg_bitstream_buffer.sv
// Directed bench with a bit-level scoreboard for jpeg_bitstream_buffer.
module tb_jpeg_bitstream_buffer;
  logic        clk = 0, rst = 1, st = 0, en = 0, iv = 0, il = 0;
  logic [7:0]  id = '0;
  logic [5:0]  pop = '0;
  logic        acc, ov, ol, mk;
  logic [31:0] od;
  logic [7:0]  lvl, mc;

  bit sbq[$];
  bit drain_m, acc_last;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  jpeg_bitstream_buffer dut (
    .clk_i(clk), .rst_i(rst), .img_start_i(st), .img_end_i(en),
    .inport_valid_i(iv), .inport_data_i(id), .inport_last_i(il),
    .inport_accept_o(acc), .outport_pop_i(pop), .outport_valid_o(ov),
    .outport_data_o(od), .outport_last_o(ol), .level_o(lvl),
    .marker_o(mk), .marker_code_o(mc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1; iv = 0; il = 0; st = 0; en = 0; pop = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    sbq.delete(); drain_m = 0;
  endtask

  // One cycle: check outputs against the model, drive, update the model, clock.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input int p,
                      input bit s, input bit e);
    int n; logic [31:0] expb, obsb; bit mv;
    mv = sbq.size() >= 32 || (drain_m && sbq.size() > 0);
    chk("accept", acc, sbq.size() <= 120);
    chk("valid", ov, mv);
    iv = v; id = d; il = l; pop = p[5:0]; st = s; en = e; acc_last = 0;
    if (mv && p > 0 && !s) begin
      n = p;
      if (n > 32) n = 32;
      if (n > sbq.size()) n = sbq.size();
      expb = '0;
      for (int i = 0; i < n; i++) expb = {expb[30:0], sbq.pop_front()};
      obsb = od >> (32 - n);
      chk("bits", obsb, expb);
    end
    if (s) begin
      sbq.delete(); drain_m = 0;
    end else begin
      if (v && acc) begin
        acc_last = 1;
        for (int i = 7; i >= 0; i--) sbq.push_back(d[i]);
        if (l) drain_m = 1;
      end
      if (e) drain_m = 1;
    end
    @(posedge clk); #1;
    chk("level", lvl, sbq.size());
    iv = 0; il = 0; pop = 0; st = 0; en = 0;
  endtask

  function automatic logic [7:0] rbyte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'hFF) b = 8'hFE;
    return b;
  endfunction

  initial begin
    int pushed, guard, pi;
    int pats[3] = '{5, 3, 17};
    logic [7:0] ubytes[5] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hD9};

    do_reset();
    chk("rst_accept", acc, 1);
    chk("rst_valid", ov, 0);
    chk("rst_data", od, 0);
    chk("rst_last", ol, 0);
    chk("rst_level", lvl, 0);
    chk("rst_marker", mk, 0);
    chk("rst_code", mc, 0);

    // Basic window and 4-bit pop
    step(1, 8'h12, 0, 0, 0, 0);
    step(1, 8'h34, 0, 0, 0, 0);
    step(1, 8'h56, 0, 0, 0, 0);
    step(1, 8'h78, 0, 0, 0, 0);
    chk("win0", od, 32'h12345678);
    step(0, 0, 0, 4, 0, 0);
    chk("win1", {4'h0, od[31:4]}, 32'h02345678);

    // img_start leaves stale RAM, so the last-window mask is exercised
    step(0, 0, 0, 0, 1, 0);
    chk("start_valid", ov, 0);
    step(1, 8'hAB, 1, 0, 0, 0);
    chk("last_flag", ol, 1);
    chk("last_data", od, 32'hAB000000);
    step(0, 0, 0, 32, 0, 0);
    chk("last_clamp_valid", ov, 0);
    chk("last_clamp_last", ol, 0);

    // Full boundary
    do_reset();
    for (int i = 0; i < 16; i++) step(1, rbyte(), 0, 0, 0, 0);
    chk("full_accept", acc, 0);
    step(1, 8'h99, 0, 0, 0, 0);
    chk("full_drop", acc_last, 0);
    step(0, 0, 0, 8, 0, 0);
    chk("full_recover", acc, 1);

    // img_start mid-stream with 72 bits stored and a byte presented
    do_reset();
    for (int i = 0; i < 9; i++) step(1, rbyte(), 0, 0, 0, 0);
    chk("pre_start_level", lvl, 72);
    step(1, 8'h55, 0, 0, 1, 0);
    chk("post_start_valid", ov, 0);
    chk("post_start_accept", acc, 1);

    // Streaming across pointer wrap, then drain
    do_reset();
    pushed = 0; guard = 0; pi = 0;
    while ((pushed < 40 || sbq.size() > 0) && guard < 1000) begin
      step(pushed < 40, rbyte(), 0, pats[pi], 0, pushed == 40 && !drain_m);
      if (acc_last) pushed++;
      pi = (pi + 1) % 3;
      guard++;
    end
    chk("stream_done", guard < 1000, 1);
    chk("stream_pushed", pushed, 40);

`ifdef JPEG_BITBUF_UNSTUFF_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      iv = 1; id = ubytes[i];
      @(posedge clk); #1;
    end
    iv = 0;
    chk("us_marker", mk, 1);
    chk("us_code", mc, 8'hD9);
    chk("us_level", lvl, 8);
    chk("us_drain_last", ol, 1);
    chk("us_data", od, 32'hFF000000);
    @(posedge clk); #1;
    chk("us_marker_pulse", mk, 0);
    chk("us_code_held", mc, 8'hD9);
`else
    chk("nomarker_code", mc, 0);
    chk("nomarker", mk, ubytes[1][0]);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
